// File: rtl/async_pkg.sv
// Shared types and limits for the clocked 4-phase bundled-data channel blocks.
// Contents: input/output handshake FSM state enums and the legal
// synchronizer-depth range.
package async_pkg;

  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 4;

  // Input side: waiting for a request, or holding the ack until req returns to zero
  typedef enum logic {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } in_state_e;

  // Output side: idle, request raised, waiting for ack return-to-zero
  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_RTZ  = 2'd2
  } out_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous control bit.
// Ports: clk, rst (async active-high), d_i (asynchronous input),
//        q_o (synchronised output, SYNC cycles behind d_i).
module sync_ff
  import async_pkg::*;
#(
  parameter int unsigned SYNC    = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  // Depth is clamped into the supported range so an illegal override still elaborates
  localparam int unsigned SYNC_EFF = (SYNC < SYNC_MIN) ? SYNC_MIN :
                                     (SYNC > SYNC_MAX) ? SYNC_MAX : SYNC;

  logic [SYNC_EFF-1:0] sync_q;
  logic [SYNC_EFF-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_EFF-2:0], d_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_EFF{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_EFF-1];

endmodule

// File: rtl/split2_sync.sv
// Clocked 1-to-2 split for 4-phase bundled-data channels. Each token on the
// input channel is buffered once and forwarded to out0 or out1 according to
// the select bit that travelled with it.
// Ports: clk, rst (async active-high);
//        input channel  r_i / a_i / d_i[N] / sel_i;
//        out0 channel   r0_o / a0_o / d0_o[N];
//        out1 channel   r1_o / a1_o / d1_o[N];
//        busy: a token is buffered or an output handshake is still running.
module split2_sync
  import async_pkg::*;
#(
  parameter int unsigned N    = 1,
  parameter int unsigned SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         sel_i,
  output logic         r0_o,
  input  logic         a0_o,
  output logic [N-1:0] d0_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o,
  output logic         busy
);

  logic r_s;
  logic a0_s;
  logic a1_s;

  sync_ff #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_r  (.clk(clk), .rst(rst), .d_i(r_i),  .q_o(r_s));
  sync_ff #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_a0 (.clk(clk), .rst(rst), .d_i(a0_o), .q_o(a0_s));
  sync_ff #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_a1 (.clk(clk), .rst(rst), .d_i(a1_o), .q_o(a1_s));

  in_state_e  in_state_q,  in_state_d;
  out_state_e out_state_q, out_state_d;
  logic [N-1:0] buf_q,  buf_d;
  logic         bsel_q, bsel_d;
  logic         full_q, full_d;
  logic         a_i_q,  a_i_d;
  logic         r0_q,   r0_d;
  logic         r1_q,   r1_d;
  logic         osel_q, osel_d;
  logic         busy_q, busy_d;
  logic         sel_ack;

  // osel_q pins the channel of the token in flight; bsel_q may be overwritten
  // by a new capture while the output side is still in O_RTZ.
  assign sel_ack = osel_q ? a1_s : a0_s;

  // Next-state logic for both FSMs. full is set only when clear and cleared
  // only when set, so the two writers never collide in one cycle.
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    buf_d       = buf_q;
    bsel_d      = bsel_q;
    full_d      = full_q;
    a_i_d       = a_i_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    osel_d      = osel_q;

    case (in_state_q)
      I_IDLE: begin
        if (r_s && !full_q) begin
          buf_d      = d_i;
          bsel_d     = sel_i;
          full_d     = 1'b1;
          a_i_d      = 1'b1;
          in_state_d = I_ACK;
        end
      end
      I_ACK: begin
        if (!r_s) begin
          a_i_d      = 1'b0;
          in_state_d = I_IDLE;
        end
      end
      default: in_state_d = I_IDLE;
    endcase

    case (out_state_q)
      O_IDLE: begin
        if (full_q) begin
          osel_d      = bsel_q;
          r0_d        = !bsel_q;
          r1_d        = bsel_q;
          out_state_d = O_REQ;
        end
      end
      O_REQ: begin
        if (sel_ack) begin
          r0_d        = 1'b0;
          r1_d        = 1'b0;
          full_d      = 1'b0;
          out_state_d = O_RTZ;
        end
      end
      O_RTZ: begin
        if (!sel_ack) begin
          out_state_d = O_IDLE;
        end
      end
      default: out_state_d = O_IDLE;
    endcase

    busy_d = full_d | (out_state_d != O_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_IDLE;
      buf_q       <= '0;
      bsel_q      <= 1'b0;
      full_q      <= 1'b0;
      a_i_q       <= 1'b0;
      r0_q        <= 1'b0;
      r1_q        <= 1'b0;
      osel_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      buf_q       <= buf_d;
      bsel_q      <= bsel_d;
      full_q      <= full_d;
      a_i_q       <= a_i_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      osel_q      <= osel_d;
      busy_q      <= busy_d;
    end
  end

  assign a_i  = a_i_q;
  assign r0_o = r0_q;
  assign r1_o = r1_q;
  assign d0_o = buf_q;
  assign d1_o = buf_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_split2_sync.sv
// Bench for split2_sync: directed handshake/latency cases on a SYNC=2 instance,
// random soak on a SYNC=3 instance, with a per-channel token scoreboard.
module tb_split2_sync;

  localparam int unsigned N = 8;
  localparam int S_AI   = 0;
  localparam int S_R0   = 1;
  localparam int S_R1   = 2;
  localparam int S_BUSY = 3;
  localparam int NTOK   = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        r_i, a_i, sel_i, r0_o, a0_o, r1_o, a1_o, busy;
  logic [1:0][N-1:0] d_i, d0_o, d1_o;

  int checks = 0;
  int errors = 0;
  int delivered [2];
  bit soak_done = 1'b0;

  // Expected tokens per (instance, channel): index = inst*2 + channel
  logic [N-1:0] expq [4][$];

  split2_sync #(.N(N), .SYNC(2)) dut_a (
    .clk(clk), .rst(rst),
    .r_i(r_i[0]), .a_i(a_i[0]), .d_i(d_i[0]), .sel_i(sel_i[0]),
    .r0_o(r0_o[0]), .a0_o(a0_o[0]), .d0_o(d0_o[0]),
    .r1_o(r1_o[0]), .a1_o(a1_o[0]), .d1_o(d1_o[0]),
    .busy(busy[0])
  );

  split2_sync #(.N(N), .SYNC(3)) dut_b (
    .clk(clk), .rst(rst),
    .r_i(r_i[1]), .a_i(a_i[1]), .d_i(d_i[1]), .sel_i(sel_i[1]),
    .r0_o(r0_o[1]), .a0_o(a0_o[1]), .d0_o(d0_o[1]),
    .r1_o(r1_o[1]), .a1_o(a1_o[1]), .d1_o(d1_o[1]),
    .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int inst, input int s);
    case (s)
      S_AI:    return a_i[inst];
      S_R0:    return r0_o[inst];
      S_R1:    return r1_o[inst];
      default: return busy[inst];
    endcase
  endfunction

  // Bounded wait for a DUT output to reach a value; timing out is a failure
  task automatic wait_sig(input string name, input int inst, input int s,
                          input logic val, input int budget);
    int n = 0;
    while (sig(inst, s) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sig(inst, s)), 32'(val));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start(input int inst, input logic [N-1:0] data, input logic sel);
    d_i[inst]   = data;
    sel_i[inst] = sel;
    r_i[inst]   = 1'b1;
    expq[inst*2 + int'(sel)].push_back(data);
  endtask

  task automatic set_ack(input int inst, input int ch, input logic v);
    if (ch == 1) a1_o[inst] = v;
    else         a0_o[inst] = v;
  endtask

  // Compare process: every cycle checks exclusivity, delivered data order and
  // data stability while a request is high.
  initial begin
    logic [3:0]   prev_r;
    logic [N-1:0] held [4];
    logic         rq;
    logic [N-1:0] dq;
    logic [N-1:0] want;
    int           k;
    prev_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_r = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          chk("mutex r0/r1", 32'(r0_o[i] & r1_o[i]), 32'd0);
          for (int ch = 0; ch < 2; ch++) begin
            k  = i*2 + ch;
            rq = (ch == 1) ? r1_o[i] : r0_o[i];
            dq = (ch == 1) ? d1_o[i] : d0_o[i];
            if (rq && !prev_r[k]) begin
              if (expq[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected token inst%0d ch%0d: got %0h expected none", i, ch, dq);
              end else begin
                want = expq[k].pop_front();
                chk($sformatf("deliver inst%0d ch%0d", i, ch), 32'(dq), 32'(want));
                delivered[i]++;
              end
              held[k] = dq;
            end else if (rq) begin
              chk($sformatf("data stable inst%0d ch%0d", i, ch), 32'(dq), 32'(held[k]));
            end
            prev_r[k] = rq;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) assert (!(r0_o[1] && r1_o[1])) else $error("FAIL mutex assertion inst1");
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic receiver(input int ch);
    while (!soak_done) begin
      @(negedge clk);
      if (sig(1, (ch == 1) ? S_R1 : S_R0)) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        set_ack(1, ch, 1'b1);
        wait_sig("soak req fall", 1, (ch == 1) ? S_R1 : S_R0, 1'b0, 100);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        set_ack(1, ch, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    r_i = '0; sel_i = '0; a0_o = '0; a1_o = '0; d_i = '0;
    delivered[0] = 0; delivered[1] = 0;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      chk("reset a_i",  32'(a_i[i]),  32'd0);
      chk("reset r0_o", 32'(r0_o[i]), 32'd0);
      chk("reset r1_o", 32'(r1_o[i]), 32'd0);
      chk("reset d0_o", 32'(d0_o[i]), 32'd0);
      chk("reset d1_o", 32'(d1_o[i]), 32'd0);
      chk("reset busy", 32'(busy[i]), 32'd0);
    end
    rst = 1'b0;
    cyc(2);

    // 1: token to out0, exact latencies
    send_start(0, 8'hA5, 1'b0);
    cyc(2); chk("t1 a_i before SYNC+1", 32'(a_i[0]), 32'd0);
    cyc(1); chk("t1 a_i at SYNC+1", 32'(a_i[0]), 32'd1);
            chk("t1 r0 before SYNC+2", 32'(r0_o[0]), 32'd0);
    cyc(1); chk("t1 r0 at SYNC+2", 32'(r0_o[0]), 32'd1);
            chk("t1 d0", 32'(d0_o[0]), 32'hA5);
            chk("t1 r1 idle", 32'(r1_o[0]), 32'd0);
            chk("t1 busy", 32'(busy[0]), 32'd1);
    r_i[0] = 1'b0;
    a0_o[0] = 1'b1;
    cyc(2); chk("t1 r0 held", 32'(r0_o[0]), 32'd1);
    cyc(1); chk("t1 r0 fall at SYNC+1", 32'(r0_o[0]), 32'd0);
            chk("t1 a_i fall", 32'(a_i[0]), 32'd0);
    a0_o[0] = 1'b0;
    cyc(2); chk("t1 busy during rtz", 32'(busy[0]), 32'd1);
    cyc(1); chk("t1 busy fall", 32'(busy[0]), 32'd0);

    // 2: token to out1 while a0 is held high (spurious/unselected ack)
    a0_o[0] = 1'b1;
    cyc(2);
    send_start(0, 8'h3C, 1'b1);
    cyc(3); chk("t2 a_i rise", 32'(a_i[0]), 32'd1);
    cyc(1); chk("t2 r1 rise", 32'(r1_o[0]), 32'd1);
            chk("t2 d1", 32'(d1_o[0]), 32'h3C);
            chk("t2 r0 idle", 32'(r0_o[0]), 32'd0);
    r_i[0] = 1'b0;
    cyc(5); chk("t2 r1 ignores a0", 32'(r1_o[0]), 32'd1);
    a1_o[0] = 1'b1;
    cyc(3); chk("t2 r1 fall", 32'(r1_o[0]), 32'd0);
    a1_o[0] = 1'b0;
    wait_sig("t2 busy fall", 0, S_BUSY, 1'b0, 10);
    a0_o[0] = 1'b0;
    cyc(4);

    // 3/4: back-pressure and the one-cycle bubble after full clears
    send_start(0, 8'h11, 1'b0);
    wait_sig("t3 a_i tok1", 0, S_AI, 1'b1, 10);
    r_i[0] = 1'b0;
    wait_sig("t3 r0 tok1", 0, S_R0, 1'b1, 10);
    wait_sig("t3 a_i tok1 fall", 0, S_AI, 1'b0, 10);
    send_start(0, 8'h22, 1'b1);
    repeat (15) begin
      @(negedge clk);
      chk("t3 back-pressure a_i", 32'(a_i[0]), 32'd0);
    end
    chk("t3 r1 idle", 32'(r1_o[0]), 32'd0);
    a0_o[0] = 1'b1;
    cyc(2); chk("t4 r0 held", 32'(r0_o[0]), 32'd1);
    cyc(1); chk("t4 r0 fall (full clears)", 32'(r0_o[0]), 32'd0);
            chk("t4 no capture same cycle", 32'(a_i[0]), 32'd0);
    a0_o[0] = 1'b0;
    cyc(1); chk("t4 capture next cycle", 32'(a_i[0]), 32'd1);
    r_i[0] = 1'b0;
    wait_sig("t3 r1 tok2", 0, S_R1, 1'b1, 10);
    chk("t3 d1 tok2", 32'(d1_o[0]), 32'h22);
    chk("t3 d0 mirrors buffer", 32'(d0_o[0]), 32'h22);
    a1_o[0] = 1'b1;
    wait_sig("t3 r1 fall", 0, S_R1, 1'b0, 10);
    a1_o[0] = 1'b0;
    wait_sig("t3 busy fall", 0, S_BUSY, 1'b0, 10);
    cyc(2);

    // 5: reset in the middle of an out0 handshake
    send_start(0, 8'h77, 1'b0);
    wait_sig("t5 r0 rise", 0, S_R0, 1'b1, 10);
    rst = 1'b1;
    #1;
    chk("t5 async r0", 32'(r0_o[0]), 32'd0);
    chk("t5 async a_i", 32'(a_i[0]), 32'd0);
    chk("t5 async busy", 32'(busy[0]), 32'd0);
    r_i[0] = 1'b0;
    a0_o[0] = 1'b0;
    cyc(2);
    expq[0].delete();
    expq[1].delete();
    rst = 1'b0;
    cyc(2);
    chk("t5 stays idle", 32'(busy[0]), 32'd0);
    send_start(0, 8'h5A, 1'b1);
    wait_sig("t5 a_i", 0, S_AI, 1'b1, 10);
    r_i[0] = 1'b0;
    wait_sig("t5 r1 rise", 0, S_R1, 1'b1, 10);
    chk("t5 d1", 32'(d1_o[0]), 32'h5A);
    a1_o[0] = 1'b1;
    wait_sig("t5 r1 fall", 0, S_R1, 1'b0, 10);
    a1_o[0] = 1'b0;
    wait_sig("t5 busy fall", 0, S_BUSY, 1'b0, 10);

    // 6: random soak on the SYNC=3 instance
    fork
      begin
        for (int t = 0; t < NTOK; t++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          send_start(1, N'($urandom), 1'($urandom_range(0, 1)));
          wait_sig("soak a_i rise", 1, S_AI, 1'b1, 100);
          r_i[1] = 1'b0;
          d_i[1] = N'($urandom);
          wait_sig("soak a_i fall", 1, S_AI, 1'b0, 100);
        end
        wait_sig("soak drain", 1, S_BUSY, 1'b0, 200);
        soak_done = 1'b1;
      end
      receiver(0);
      receiver(1);
    join
    cyc(2);
    chk("soak delivered", 32'(delivered[1]), 32'(NTOK));
    chk("soak ch0 drained", 32'(expq[2].size()), 32'd0);
    chk("soak ch1 drained", 32'(expq[3].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
